// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and types for the instruction-fetch stage
package fetch_pkg;
  localparam int ADDR_W = 32;
  localparam int INSTR_W = 32;
  localparam int WORD_BYTES = 4;
  localparam int QDEPTH_DEF = 2;
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
  typedef logic [$clog2(QDEPTH_DEF+1)-1:0] qcount_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small sync FIFO with flush, occupancy count and same-cycle push/pop
module fetch_queue #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_data,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic          w_pop;
  assign w_pop   = i_pop & (r_count != '0);
  assign o_data  = r_mem[r_rd];
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(w_pop);
    end
  end
  // upstream credit accounting must make a push into a full queue impossible
  always @(posedge clk)
    if (rst_n && !i_flush) assert (!(i_push && !w_pop && r_count == CW'(DEPTH)));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing in-order imem reads, buffering words for decode, flushing on redirect
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2,
  parameter int          MAX_OUT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int CW = $clog2(QDEPTH+1);
  localparam int OW = $clog2(MAX_OUT+1);
  logic [31:0]   r_pc, r_req_addr;
  logic [OW-1:0] r_out, r_drop;
  logic          r_req_pend, r_pend_drop;
  logic [CW-1:0] w_qcount;
  logic [OW-1:0] w_tag_count, w_out_nxt;
  logic [31:0]   w_tag;
  logic          w_q_empty, w_tag_empty, w_credit, w_acc, w_hold, w_push, w_pop, w_drop_rsp;
  logic          w_unused;
  fetch_entry_t  w_head, w_entry;
  assign w_unused       = ^redirect_pc[1:0];
  assign w_credit       = (32'(r_out) + 32'(w_qcount) < 32'(QDEPTH)) && (r_out < OW'(MAX_OUT));
  assign imem_req_valid = reset & (r_req_pend | w_credit);
  assign imem_req_addr  = r_req_pend ? r_req_addr : r_pc;
  assign w_acc          = imem_req_valid & imem_req_ready;
  assign w_hold         = imem_req_valid & ~imem_req_ready;
  assign w_drop_rsp     = imem_rsp_valid & (r_drop != '0);
  assign w_push         = imem_rsp_valid & (r_drop == '0) & ~redirect;
  assign w_pop          = ~w_q_empty & instr_ready & ~redirect;
  assign w_out_nxt      = r_out + OW'(w_acc) - OW'(imem_rsp_valid);
  assign w_entry        = '{pc: w_tag, instr: imem_rsp_data};
  assign instr_valid    = ~w_q_empty;
  assign instr          = w_head.instr;
  assign instr_pc       = w_head.pc;
  // every in-flight request, including a held one accepted later, is stale once redirected
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= RESET_PC;
      r_req_addr  <= '0;
      r_out       <= '0;
      r_drop      <= '0;
      r_req_pend  <= 1'b0;
      r_pend_drop <= 1'b0;
    end else begin
      r_out       <= w_out_nxt;
      r_req_pend  <= w_hold;
      r_req_addr  <= imem_req_addr;
      r_pend_drop <= w_hold & (redirect | r_pend_drop);
      r_drop      <= redirect ? w_out_nxt : r_drop - OW'(w_drop_rsp) + OW'(w_acc & r_pend_drop);
      r_pc        <= redirect ? {redirect_pc[31:2], 2'b00} :
                     (w_acc & ~r_pend_drop) ? r_pc + 32'(WORD_BYTES) : r_pc;
    end
  end
  fetch_queue #(.W($bits(fetch_entry_t)), .DEPTH(QDEPTH)) u_iq (
    .clk     (clk),
    .rst_n   (reset),
    .i_flush (redirect),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_q_empty),
    .o_count (w_qcount)
  );
  // tags are never flushed: dropped responses still retire their tag in order
  fetch_queue #(.W(32), .DEPTH(MAX_OUT)) u_tag (
    .clk     (clk),
    .rst_n   (reset),
    .i_flush (1'b0),
    .i_push  (w_acc),
    .i_data  (imem_req_addr),
    .i_pop   (imem_rsp_valid),
    .o_data  (w_tag),
    .o_empty (w_tag_empty),
    .o_count (w_tag_count)
  );
  always @(posedge clk)
    if (reset) begin
      assert (!(imem_rsp_valid && w_tag_empty));
      assert (w_tag_count == r_out);
      assert (r_drop <= r_out);
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit with an in-order imem model
module tb_fetch_unit;
  localparam logic [31:0] K = 32'hE000_0000;
  logic        clk = 1'b0, reset = 1'b0, imem_req_ready = 1'b1, instr_ready = 1'b0;
  logic        redirect = 1'b0, hold = 1'b0, chk_en = 1'b1;
  logic [31:0] redirect_pc = '0, last_acc = '0, held = '0;
  logic        imem_req_valid, imem_rsp_valid, instr_valid;
  logic [31:0] imem_req_addr, imem_rsp_data, instr, instr_pc;
  logic [31:0] mq[$], exp_q[$];
  int          n_err = 0, n_chk = 0, n_del = 0, acc_cnt = 0, a0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc)
  );

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        mq.push_back(imem_req_addr);
        acc_cnt  <= acc_cnt + 1;
        last_acc <= imem_req_addr;
      end
      if (!hold && mq.size() != 0) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mq.pop_front() ^ K;
      end else imem_rsp_valid <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    if (instr_valid === 1'b1 && instr_ready && !redirect) begin
      n_del++;
      if (chk_en) begin
        check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("instr_pc", instr_pc, e);
          check("instr", instr, e ^ K);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_del(input int n, input string tag);
    int base = n_del;
    for (int i = 0; i < 200 && n_del - base < n; i++) tick();
    check(tag, 32'(n_del - base), 32'(n));
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redirect    = 1'b1;
    redirect_pc = tgt;
    exp_q.delete();
    chk_en = 1'b1;
    tick();
    redirect = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    instr_ready = 1'b1;
    repeat (3) tick();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    reset = 1'b1;
    #1;
    check("c0_req_valid", 32'(imem_req_valid), 32'd1);
    check("c0_req_addr", imem_req_addr, 32'd0);
    check("c0_instr_valid", 32'(instr_valid), 32'd0);
    tick();
    check("c1_instr_valid", 32'(instr_valid), 32'd0);
    tick();
    check("c2_instr_valid", 32'(instr_valid), 32'd1);
    check("c2_instr_pc", instr_pc, 32'd0);
    wait_del(8, "p1_count");
    instr_ready = 1'b0;
    repeat (6) tick();
    check("full_valid", 32'(instr_valid), 32'd1);
    check("full_no_req", 32'(imem_req_valid), 32'd0);
    check("full_head", instr_pc, 32'h20);
    reset = 1'b0;
    #1;
    check("mid_rst_instr_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("mid_rst_instr_pc", instr_pc, 32'd0);
    exp_q.delete();
    tick();
    reset = 1'b1;
    a0 = acc_cnt;
    repeat (10) tick();
    check("p2_accepts", 32'(acc_cnt - a0), 32'd2);
    check("p2_no_req", 32'(imem_req_valid), 32'd0);
    check("p2_head", instr_pc, 32'd0);
    for (int i = 0; i < 3; i++) exp_q.push_back(32'(i * 4));
    instr_ready = 1'b1;
    wait_del(3, "p2_count");
    instr_ready = 1'b0;
    chk_en = 1'b0;
    hold = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 30 && !(mq.size() == 2 && !instr_valid); i++) tick();
    check("p3_outstanding", 32'(mq.size()), 32'd2);
    do_redirect(32'h100);
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h100 + 32'(i * 4));
    hold = 1'b0;
    check("p3_flush_valid", 32'(instr_valid), 32'd0);
    check("p3_no_req", 32'(imem_req_valid), 32'd0);
    wait_del(3, "p3_count");
    instr_ready = 1'b0;
    chk_en = 1'b0;
    instr_ready = 1'b1;
    imem_req_ready = 1'b0;
    repeat (6) tick();
    held = last_acc + 32'd4;
    check("p4_pend_valid", 32'(imem_req_valid), 32'd1);
    check("p4_pend_addr", imem_req_addr, held);
    do_redirect(32'h200);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    check("p4_flush_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("p4_hold_valid", 32'(imem_req_valid), 32'd1);
      check("p4_hold_addr", imem_req_addr, held);
      tick();
    end
    imem_req_ready = 1'b1;
    tick();
    check("p4_stale_accept", last_acc, held);
    check("p4_next_valid", 32'(imem_req_valid), 32'd1);
    check("p4_next_addr", imem_req_addr, 32'h200);
    wait_del(2, "p4_count");
    do_redirect(32'hFFFF_FFFC);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    wait_del(3, "p5_wrap_count");
    do_redirect(32'h203);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    check("p5_flush_valid", 32'(instr_valid), 32'd0);
    wait_del(2, "p5_align_count");
    instr_ready = 1'b0;
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
